// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with mid-bit sampling, parity/stop checks and a one-entry valid/ready holding register
module uart_rx_core #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DIV_W-1:0] i_divisor,
    input  logic             i_parity_en,
    input  logic             i_parity_odd,
    input  logic             i_rx,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [7:0]       o_m_data,
    output logic             o_frame_err,
    output logic             o_parity_err,
    output logic             o_overrun,
    output logic             o_rts_n,
    output logic             o_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t           r_state, w_state_nxt;
    logic             r_sync, r_rx_s, r_rx_p;
    logic [DIV_W-1:0] r_cnt, r_div_l, w_div_eff;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift, r_m_data;
    logic             r_pen, r_podd, r_perr, r_m_valid, r_frame_err, r_parity_err, r_overrun, r_rts_n;
    logic             w_start, w_sample, w_stop, w_deliver, w_load, w_valid_nxt;

    always_comb begin
        w_div_eff   = (i_divisor < DIV_W'(4)) ? DIV_W'(4) : i_divisor;
        w_start     = (r_state == IDLE) && r_rx_p && !r_rx_s;
        w_sample    = (r_state != IDLE) && (r_cnt == '0);
        w_stop      = w_sample && (r_state == STOP);
        w_deliver   = w_stop && r_rx_s && !r_perr;
        w_load      = w_deliver && (!r_m_valid || i_m_ready);
        w_valid_nxt = w_load || (r_m_valid && !i_m_ready);
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_start ? START : IDLE;
            START:   if (w_sample) w_state_nxt = r_rx_s ? IDLE : DATA;
            DATA:    if (w_sample && r_bit == 3'd7) w_state_nxt = r_pen ? PARITY : STOP;
            PARITY:  if (w_sample) w_state_nxt = STOP;
            STOP:    if (w_sample) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            {r_sync, r_rx_s, r_rx_p} <= 3'b111;
            r_cnt        <= '0;
            r_div_l      <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_pen        <= 1'b0;
            r_podd       <= 1'b0;
            r_perr       <= 1'b0;
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_rts_n      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            {r_sync, r_rx_s, r_rx_p} <= {i_rx, r_sync, r_rx_s};
            // frame settings are frozen at start detection
            if (w_start) begin
                r_div_l <= w_div_eff;
                r_cnt   <= (w_div_eff >> 1) - DIV_W'(1);
                r_pen   <= i_parity_en;
                r_podd  <= i_parity_odd;
                r_perr  <= 1'b0;
                r_bit   <= '0;
            end else if (r_state != IDLE) begin
                r_cnt <= w_sample ? r_div_l - DIV_W'(1) : r_cnt - DIV_W'(1);
            end
            if (r_state == DATA && w_sample) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (r_state == PARITY && w_sample && (r_rx_s != (^r_shift ^ r_podd))) r_perr <= 1'b1;
            if (w_load) r_m_data <= r_shift;
            r_m_valid    <= w_valid_nxt;
            r_rts_n      <= w_valid_nxt;
            r_frame_err  <= w_stop && !r_rx_s;
            r_parity_err <= w_stop && r_rx_s && r_perr;
            r_overrun    <= w_deliver && !w_load;
        end
    end

    assign o_m_valid    = r_m_valid;
    assign o_m_data     = r_m_data;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_overrun    = r_overrun;
    assign o_rts_n      = r_rts_n;
    assign o_busy       = (r_state != IDLE);
endmodule
